time_display: RTL and testbench
===============================

# time_display

Two-digit 7-segment driver for the push-box countdown. It consumes the 6-bit `time_remain` seconds value from the countdown timer. A sequential double-dabble converter turns that value into BCD tens/ones, and the block multiplexes both digits onto a common-anode display. It sits directly downstream of the countdown timer, between it and the board's segment/digit pins.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: input clock frequency.
- `SCAN_HZ`, 1000: digit-switch rate; each digit is lit for CLK_HZ/SCAN_HZ cycles.
- `WARN_THRESH`, 10: warning-blink threshold in seconds (used only with the macro).
- `BLINK_HZ`, 2: blink rate (used only with the macro).

Ports:
- `clk50M` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; async active-low reset is fixed.
- `time_remain` in 6: seconds remaining, binary, 0–63.
- `seg` out 8: segments, active-low; [7]=dp, [6:0]=g..a.
- `dig` out 2: digit enables, active-low; [0]=ones, [1]=tens.
- `bcd_tens` out 4: committed tens digit.
- `bcd_ones` out 4: committed ones digit.
- `conv_busy` out 1: high while a conversion is in progress.

## Operation
- **Reset values:**
  - `last_val`=60, `bcd_tens`=6, `bcd_ones`=0, `conv_busy`=0.
  - `seg`=8'hFF, `dig`=2'b11.
  - Scan and blink counters=0, digit index=0, FSM=IDLE.
- **Converter FSM:** states IDLE, SHIFT, DONE.
  - **IDLE:** if `time_remain` != `last_val`:
    - latch `time_remain` into a shift register and into `last_val`;
    - clear the BCD scratch;
    - set `conv_busy`=1 and go to SHIFT.
  - **SHIFT:** exactly 6 cycles. Each cycle:
    - add 3 to any scratch nibble >=5;
    - then shift {scratch, bin} left by 1.
  - **DONE:** one cycle.
    - Commit the scratch to `bcd_tens`/`bcd_ones`.
    - Set `conv_busy`=0 and return to IDLE.
- **Input changes:**
  - A change of `time_remain` during SHIFT/DONE is ignored until IDLE.
  - IDLE then compares against `last_val`, so the newest value is always converted next.
  - An intermediate value may be skipped.
- **Input range:** 60–63 are converted normally (e.g. 63 -> 6/3). There is no clamping.
- **Scan:**
  - A free-running counter wraps at CLK_HZ/SCAN_HZ−1; on wrap it toggles the digit index.
  - Index 0 drives `dig`=2'b10 with the ones pattern.
  - Index 1 drives `dig`=2'b01 with the tens pattern.
- **Leading-zero blanking:** when `bcd_tens`==0, the tens slot outputs `seg`=8'hFF. `dig` still cycles.
- **Segment codes** (dp off, active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Codes 10–15 give 8'hFF.
- `seg`/`dig` are registered from the committed BCD. The display never shows scratch values.

## Timing
- **Conversion latency:**
  - input change sampled at edge N;
  - `conv_busy` high from N+1;
  - BCD outputs updated at edge N+8 (1 load + 6 shift + 1 commit);
  - `conv_busy` low at N+8.
- **Display latency:** committed BCD appears on `seg` no later than the next digit slot. Worst case is one scan period plus 1 cycle.
- **Reset mid-conversion:** immediate abort to the reset values. No partial result is committed.
- **Scan-counter width:** clog2(CLK_HZ/SCAN_HZ). The blink counter is sized the same way from CLK_HZ/(2*BLINK_HZ).

## Configuration
- `TIME_DISPLAY_BLINK_EN` defined:
  - A blink counter toggles a phase bit every CLK_HZ/(2*BLINK_HZ) cycles.
  - While committed value <= WARN_THRESH and the phase bit is 1, `dig`=2'b11 and `seg`=8'hFF.
  - Otherwise the display behaves normally.
  - The phase bit resets to 0 (display on).
- Undefined:
  - No blink counter or phase logic is present.
  - The display is always on regardless of value.
  - `WARN_THRESH`/`BLINK_HZ` are unused.

## Test plan
Benches run with CLK_HZ=1000, SCAN_HZ=100 (10-cycle digit slot) and BLINK_HZ=50 (10-cycle phase).

1. **Reset, hold `time_remain`=60** -> no conversion, `conv_busy` stays 0. `bcd_tens`/`bcd_ones`=6/0. Slots alternate `dig`=10 with `seg`=C0 and `dig`=01 with `seg`=82.
2. **Step `time_remain` 60->37 at edge N** -> `conv_busy` high N+1..N+7. `bcd_tens`/`bcd_ones`=3/7 at N+8. `seg` shows F8 in the ones slot and B0 in the tens slot.
3. **`time_remain`=5** -> tens slot `seg`=FF with `dig`=01. Ones slot `seg`=92.
4. **Change 37->20 at N, then 20->19 at N+3** -> 2/0 committed at N+8. A second conversion starts at N+9 and commits 1/9 at N+16.
5. **Assert `rst_n`=0 during SHIFT** -> outputs return to the reset values at once. After release the display shows 60 until `time_remain` differs.
6. **`time_remain`=9**:
   - with `TIME_DISPLAY_BLINK_EN`: `dig`=11 for the first 10 cycles, active for the next 10, repeating;
   - without it: `dig` never 11 after the first slot.

Source files
------------

// File: rtl/time_display.sv
// time_display: two-digit common-anode 7-segment driver for the push-box
// countdown. A 6-bit seconds value is turned into BCD by a sequential
// double-dabble converter, and the two committed digits are multiplexed
// onto the display.
//
// Ports:
//   clk50M       system clock
//   rst_n        asynchronous active-low reset
//   time_remain  seconds remaining, binary 0..63
//   seg          segments, active-low, [7]=dp, [6:0]=g..a
//   dig          digit enables, active-low, [0]=ones, [1]=tens
//   bcd_tens     committed tens digit
//   bcd_ones     committed ones digit
//   conv_busy    high while a conversion is in progress
//
// Build option: define TIME_DISPLAY_BLINK_EN to blank the whole display on
// alternate blink phases while the committed value is <= WARN_THRESH.
module time_display #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int WARN_THRESH = 10,
  parameter int BLINK_HZ    = 2
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic [5:0] time_remain,
  output logic [7:0] seg,
  output logic [1:0] dig,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       conv_busy
);

  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // Elaboration-time sanity check of the configuration.
  if (SCAN_HZ <= 0 || CLK_HZ < SCAN_HZ || BLINK_HZ <= 0 || WARN_THRESH < 0) begin : g_bad_cfg
    $error("time_display: invalid clock/scan/blink configuration");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  in_q;
  logic [5:0]  last_q, last_d;
  logic [13:0] sh_q, sh_d;        // {tens, ones, binary}
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        busy_q, busy_d;

  logic [SCAN_W-1:0] scan_q;
  logic              idx_q;
  logic [7:0]        seg_q, seg_d;
  logic [1:0]        dig_q, dig_d;

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  function automatic logic [13:0] dabble_step(input logic [13:0] v);
    logic [13:0] t;
    t = v;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Input register: the converter compares a registered copy of the input,
  // so a change takes one edge to be seen and the load happens on the next.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      in_q    <= 6'd60;
      last_q  <= 6'd60;
      sh_q    <= '0;
      cnt_q   <= '0;
      tens_q  <= 4'd6;
      ones_q  <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= time_remain;
      last_q  <= last_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        // Compare against the last converted value, not the previous
        // sample, so a change that arrived mid-conversion is still picked up.
        if (in_q != last_q) begin
          last_d  = in_q;
          sh_d    = {8'd0, in_q};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sh_d  = dabble_step(sh_q);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_d = S_DONE;
      end
      S_DONE: begin
        tens_d  = sh_q[13:10];
        ones_d  = sh_q[9:6];
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef TIME_DISPLAY_BLINK_EN
  localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_q;
  logic               phase_q;
  logic [6:0]         value_c;
  logic               blank_c;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (blink_q == BLINK_LAST) begin
      blink_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  assign value_c = 7'(tens_q) * 7'd10 + 7'(ones_q);
  assign blank_c = phase_q && (32'(value_c) <= 32'(WARN_THRESH));
`else
  logic blank_c;
  assign blank_c = 1'b0;
`endif

  // Digit scan: the index flips each time the slot counter wraps.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= 1'b0;
      seg_q  <= 8'hFF;
      dig_q  <= 2'b11;
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q <= '0;
        idx_q  <= ~idx_q;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  // Only committed digits reach the pins; the tens slot is blanked on zero.
  always_comb begin
    seg_d = seg7(ones_q);
    dig_d = 2'b10;
    if (idx_q) begin
      seg_d = (tens_q == 4'd0) ? 8'hFF : seg7(tens_q);
      dig_d = 2'b01;
    end
    if (blank_c) begin
      seg_d = 8'hFF;
      dig_d = 2'b11;
    end
  end

  assign seg       = seg_q;
  assign dig       = dig_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign conv_busy = busy_q;

endmodule

// File: tb/tb_time_display.sv
module tb_time_display;
  localparam int CLK_HZ   = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int WARN     = 10;
  localparam int BLINK_HZ = 50;
  localparam int SDIV     = CLK_HZ / SCAN_HZ;
  localparam int BDIV     = CLK_HZ / (2 * BLINK_HZ);

  logic       clk50M = 1'b0;
  logic       rst_n  = 1'b0;
  logic [5:0] time_remain = 6'd60;
  logic [7:0] seg;
  logic [1:0] dig;
  logic [3:0] bcd_tens, bcd_ones;
  logic       conv_busy;

  int tests = 0;
  int fails = 0;

  time_display #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .WARN_THRESH(WARN), .BLINK_HZ(BLINK_HZ)) dut (
    .clk50M(clk50M), .rst_n(rst_n), .time_remain(time_remain), .seg(seg), .dig(dig),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .conv_busy(conv_busy)
  );

  always #5 clk50M = ~clk50M;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int code(input int d);
    case (d)
      0: return 'hC0; 1: return 'hF9; 2: return 'hA4; 3: return 'hB0; 4: return 'h99;
      5: return 'h92; 6: return 'h82; 7: return 'hF8; 8: return 'h80; 9: return 'h90;
      default: return 'hFF;
    endcase
  endfunction

  // Reference model: conversion is a countdown of 7 edges after the load,
  // committing value/10 and value%10; display derives from committed digits.
  int m_in = 60, m_last = 60, m_pend = 60, m_left = 0;
  int m_tens = 6, m_ones = 0;
  int m_seg = 'hFF, m_dig = 3;
  int m_scnt = 0, m_bcnt = 0;
  bit m_idx = 1'b0, m_phase = 1'b0;

  always @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      m_in <= 60; m_last <= 60; m_pend <= 60; m_left <= 0;
      m_tens <= 6; m_ones <= 0; m_seg <= 'hFF; m_dig <= 3;
      m_scnt <= 0; m_bcnt <= 0; m_idx <= 1'b0; m_phase <= 1'b0;
    end else begin
      if (m_left == 0) begin
        if (m_in != m_last) begin
          m_last <= m_in; m_pend <= m_in; m_left <= 7;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_tens <= m_pend / 10;
          m_ones <= m_pend % 10;
        end
      end
      if (m_idx) begin
        m_dig <= 1;
        m_seg <= (m_tens == 0) ? 'hFF : code(m_tens);
      end else begin
        m_dig <= 2;
        m_seg <= code(m_ones);
      end
`ifdef TIME_DISPLAY_BLINK_EN
      if (m_phase && (m_tens * 10 + m_ones) <= WARN) begin
        m_dig <= 3;
        m_seg <= 'hFF;
      end
`endif
      if (m_scnt == SDIV - 1) begin m_scnt <= 0; m_idx <= ~m_idx; end
      else m_scnt <= m_scnt + 1;
      if (m_bcnt == BDIV - 1) begin m_bcnt <= 0; m_phase <= ~m_phase; end
      else m_bcnt <= m_bcnt + 1;
      m_in <= int'(time_remain);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk50M) begin
    chk("seg", int'(seg), m_seg);
    chk("dig", int'(dig), m_dig);
    chk("bcd_tens", int'(bcd_tens), m_tens);
    chk("bcd_ones", int'(bcd_ones), m_ones);
    chk("conv_busy", int'(conv_busy), (m_left != 0) ? 1 : 0);
  end

  task automatic check_slots(input string name, input int exp_ones, input int exp_tens, input int cycles);
    bit seen0, seen1;
    seen0 = 0; seen1 = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk50M);
      if (dig == 2'b10) begin seen0 = 1; chk({name, "_ones_seg"}, int'(seg), exp_ones); end
      if (dig == 2'b01) begin seen1 = 1; chk({name, "_tens_seg"}, int'(seg), exp_tens); end
    end
    chk({name, "_both_slots_seen"}, int'(seen0 & seen1), 1);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_seg"}, int'(seg), 'hFF);
    chk({name, "_dig"}, int'(dig), 3);
    chk({name, "_tens"}, int'(bcd_tens), 6);
    chk({name, "_ones"}, int'(bcd_ones), 0);
    chk({name, "_busy"}, int'(conv_busy), 0);
  endtask

  int blanks;

  initial begin
    // Reset, hold 60
    repeat (3) @(negedge clk50M);
    check_reset_vals("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk50M);
      chk("hold60_busy", int'(conv_busy), 0);
    end
    chk("hold60_tens", int'(bcd_tens), 6);
    chk("hold60_ones", int'(bcd_ones), 0);
    check_slots("hold60", 'hC0, 'h82, 25);

    // Step 60 -> 37, sampled at edge N
    time_remain = 6'd37;
    @(negedge clk50M);
    chk("s37_busy_N", int'(conv_busy), 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk50M);
      chk("s37_busy_high", int'(conv_busy), 1);
    end
    @(negedge clk50M);
    chk("s37_busy_N8", int'(conv_busy), 0);
    chk("s37_tens", int'(bcd_tens), 3);
    chk("s37_ones", int'(bcd_ones), 7);
    check_slots("s37", 'hF8, 'hB0, 25);

    // Single digit: tens blanked
    time_remain = 6'd5;
    repeat (12) @(negedge clk50M);
    check_slots("s05", 'h92, 'hFF, 25);

    // Back-to-back changes 37 -> 20 -> 19
    time_remain = 6'd37;
    repeat (30) @(negedge clk50M);
    time_remain = 6'd20;
    repeat (3) @(negedge clk50M);
    time_remain = 6'd19;
    repeat (6) @(negedge clk50M);
    chk("b2b_first_tens", int'(bcd_tens), 2);
    chk("b2b_first_ones", int'(bcd_ones), 0);
    chk("b2b_first_busy", int'(conv_busy), 0);
    @(negedge clk50M);
    chk("b2b_second_start", int'(conv_busy), 1);
    repeat (6) @(negedge clk50M);
    chk("b2b_mid_tens", int'(bcd_tens), 2);
    @(negedge clk50M);
    chk("b2b_second_tens", int'(bcd_tens), 1);
    chk("b2b_second_ones", int'(bcd_ones), 9);
    chk("b2b_second_busy", int'(conv_busy), 0);

    // Reset during SHIFT
    repeat (5) @(negedge clk50M);
    time_remain = 6'd42;
    repeat (4) @(negedge clk50M);
    chk("midrst_busy_before", int'(conv_busy), 1);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    time_remain = 6'd60;
    @(negedge clk50M);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk50M);
      chk("postrst_busy", int'(conv_busy), 0);
    end
    chk("postrst_tens", int'(bcd_tens), 6);
    chk("postrst_ones", int'(bcd_ones), 0);
    check_slots("postrst", 'hC0, 'h82, 25);

    // Warning value 9: blink behaviour
    time_remain = 6'd9;
    repeat (40) @(negedge clk50M);
    blanks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk50M);
      if (dig == 2'b11) blanks++;
    end
`ifdef TIME_DISPLAY_BLINK_EN
    chk("blink_blanks", int'(blanks), 20);
`else
    chk("noblink_blanks", int'(blanks), 0);
`endif

    // Randomized input changes with occasional resets
    for (int i = 0; i < 250; i++) begin
      time_remain = 6'($urandom_range(0, 63));
      if ((i % 5) == 0) time_remain = 6'($urandom_range(58, 63));
      repeat ($urandom_range(1, 20)) @(negedge clk50M);
      if ((i % 40) == 17) begin
        #3 rst_n = 1'b0;
        @(negedge clk50M);
        rst_n = 1'b1;
      end
    end
    repeat (30) @(negedge clk50M);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
